// File: rtl/miss_refill_arbiter.sv
// Miss/refill arbiter: puts I-cache and D-cache miss traffic onto one shared
// memory port. A D-cache miss takes priority over an I-cache miss. A dirty
// victim is written back before the D-cache refill starts.
module miss_refill_arbiter #(
  parameter int WORDS = 4,
  parameter int IW    = 2,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ic_miss,
  input  logic [AW-1:0] ic_addr,
  input  logic          dc_miss,
  input  logic [AW-1:0] dc_addr,
  input  logic          dc_dirty,
  input  logic [AW-1:0] dc_victim_addr,
  input  logic [DW-1:0] dc_wb_data,
  output logic [IW-1:0] wb_idx,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          fill_we,
  output logic          fill_sel,
  output logic [IW-1:0] fill_idx,
  output logic [DW-1:0] fill_data,
  output logic          ic_done,
  output logic          dc_done,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, D_WB, D_FILL, I_FILL, DONE} state_t;

  localparam logic [IW-1:0] LAST_BEAT = IW'(WORDS - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] beat, beat_nxt;
  logic [AW-1:0] miss_base, miss_base_nxt;
  logic [AW-1:0] vic_base, vic_base_nxt;
  logic          req_d, req_d_nxt;   // latched requester: 1 = D-cache, 0 = I-cache

  // Align an address down to the start of its cache block.
  function automatic logic [AW-1:0] block_base(input logic [AW-1:0] a);
    return {a[AW-1:IW], {IW{1'b0}}};
  endfunction

  // Form a beat address from a block base and a word index.
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base,
                                              input logic [IW-1:0] b);
    return base | AW'(b);
  endfunction

  // State, beat counter and latched transaction parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      miss_base <= '0;
      vic_base  <= '0;
      req_d     <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      miss_base <= miss_base_nxt;
      vic_base  <= vic_base_nxt;
      req_d     <= req_d_nxt;
    end
  end

  // Next-state logic and outputs. All outputs are forced low while rst is
  // high, so a reset mid-transaction is silent in the same cycle.
  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat;
    miss_base_nxt = miss_base;
    vic_base_nxt  = vic_base;
    req_d_nxt     = req_d;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    wb_idx        = '0;
    fill_we       = 1'b0;
    fill_sel      = 1'b0;
    fill_idx      = '0;
    fill_data     = '0;
    ic_done       = 1'b0;
    dc_done       = 1'b0;
    busy          = 1'b0;

    case (state)
      IDLE: begin
        if (dc_miss) begin
          req_d_nxt     = 1'b1;
          miss_base_nxt = block_base(dc_addr);
          if (dc_dirty) begin
            vic_base_nxt = block_base(dc_victim_addr);
            state_nxt    = D_WB;
          end else begin
            state_nxt = D_FILL;
          end
        end else if (ic_miss) begin
          req_d_nxt     = 1'b0;
          miss_base_nxt = block_base(ic_addr);
          state_nxt     = I_FILL;
        end
      end
      D_WB, D_FILL, I_FILL: begin
        if (mem_ack) begin
          if (beat == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = (state == D_WB) ? D_FILL : DONE;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        D_WB: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = beat_addr(vic_base, beat);
          mem_wdata = dc_wb_data;
          wb_idx    = beat;
        end
        D_FILL, I_FILL: begin
          mem_req   = 1'b1;
          mem_addr  = beat_addr(miss_base, beat);
          fill_we   = mem_ack;
          fill_sel  = (state == D_FILL);
          fill_idx  = beat;
          fill_data = mem_rdata;
        end
        DONE: begin
          dc_done = req_d;
          ic_done = !req_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miss_refill_arbiter.sv
// Directed bench for miss_refill_arbiter: a vector table for the clean and
// dirty D-cache misses and a spurious ack, plus hand-written sequences for
// wait states, simultaneous misses and reset during a refill.
module tb_miss_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_miss, dc_miss, dc_dirty, mem_ack;
  logic [15:0] ic_addr, dc_addr, dc_victim_addr, dc_wb_data, mem_rdata;
  logic [1:0]  wb_idx, fill_idx;
  logic        mem_req, mem_we, fill_we, fill_sel, ic_done, dc_done, busy;
  logic [15:0] mem_addr, mem_wdata, fill_data;

  int total = 0;
  int bad   = 0;

  miss_refill_arbiter #(.WORDS(4), .IW(2), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .ic_miss(ic_miss), .ic_addr(ic_addr),
    .dc_miss(dc_miss), .dc_addr(dc_addr), .dc_dirty(dc_dirty),
    .dc_victim_addr(dc_victim_addr), .dc_wb_data(dc_wb_data), .wb_idx(wb_idx),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .fill_we(fill_we), .fill_sel(fill_sel), .fill_idx(fill_idx), .fill_data(fill_data),
    .ic_done(ic_done), .dc_done(dc_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Victim cache read port: word at wb_idx is 0xA000 + index.
  assign dc_wb_data = 16'hA000 + {14'd0, wb_idx};

  typedef struct packed {
    logic rst, icm; logic [15:0] ica;
    logic dcm; logic [15:0] dca; logic dirty; logic [15:0] vic;
    logic ack; logic [15:0] rdata;
  } ins_t;

  typedef struct packed {
    logic req, we; logic [15:0] addr, wdata; logic [1:0] wbi;
    logic fwe, fsel; logic [1:0] fidx; logic [15:0] fdata;
    logic icd, dcd, busy;
  } outs_t;

  typedef struct packed { ins_t i; outs_t o; } vec_t;

  vec_t  vecs[$];
  string labels[$];

  function automatic ins_t mk_in(logic r, logic icm, logic [15:0] ica, logic dcm,
                                 logic [15:0] dca, logic dirty, logic [15:0] vic,
                                 logic ack, logic [15:0] rdata);
    ins_t i;
    i.rst = r; i.icm = icm; i.ica = ica; i.dcm = dcm; i.dca = dca;
    i.dirty = dirty; i.vic = vic; i.ack = ack; i.rdata = rdata;
    return i;
  endfunction

  function automatic outs_t wr_o(logic [15:0] addr, logic [15:0] wdata, logic [1:0] wbi);
    outs_t o = '0;
    o.req = 1'b1; o.we = 1'b1; o.addr = addr; o.wdata = wdata; o.wbi = wbi; o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t rd_o(logic [15:0] addr, logic fsel, logic [1:0] fidx,
                                 logic ack, logic [15:0] rdata);
    outs_t o = '0;
    o.req = 1'b1; o.addr = addr; o.fwe = ack; o.fsel = fsel; o.fidx = fidx;
    o.fdata = rdata; o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t done_o(logic icd, logic dcd);
    outs_t o = '0;
    o.icd = icd; o.dcd = dcd; o.busy = 1'b1;
    return o;
  endfunction

  function automatic void push(string l, ins_t i, outs_t o);
    vec_t v;
    v.i = i; v.o = o;
    vecs.push_back(v);
    labels.push_back(l);
  endfunction

  task automatic drive(input ins_t i);
    rst = i.rst; ic_miss = i.icm; ic_addr = i.ica;
    dc_miss = i.dcm; dc_addr = i.dca; dc_dirty = i.dirty; dc_victim_addr = i.vic;
    mem_ack = i.ack; mem_rdata = i.rdata;
  endtask

  task automatic check(input string name, input outs_t e);
    outs_t a;
    a.req = mem_req; a.we = mem_we; a.addr = mem_addr; a.wdata = mem_wdata;
    a.wbi = wb_idx; a.fwe = fill_we; a.fsel = fill_sel; a.fidx = fill_idx;
    a.fdata = fill_data; a.icd = ic_done; a.dcd = dc_done; a.busy = busy;
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s @%0t: got req=%b we=%b addr=%h wdata=%h wbi=%0d fwe=%b fsel=%b fidx=%0d fdata=%h icd=%b dcd=%b busy=%b | want req=%b we=%b addr=%h wdata=%h wbi=%0d fwe=%b fsel=%b fidx=%0d fdata=%h icd=%b dcd=%b busy=%b",
               name, $time, a.req, a.we, a.addr, a.wdata, a.wbi, a.fwe, a.fsel, a.fidx,
               a.fdata, a.icd, a.dcd, a.busy, e.req, e.we, e.addr, e.wdata, e.wbi, e.fwe,
               e.fsel, e.fidx, e.fdata, e.icd, e.dcd, e.busy);
    end
  endtask

  // One clock cycle: apply inputs, check settled outputs, advance past the edge.
  task automatic cyc(input string name, input ins_t i, input outs_t e);
    drive(i);
    #1;
    check(name, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        ack;
    logic [15:0] rd;

    drive(mk_in(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0));
    @(posedge clk);
    #1;

    // Reset holds everything at zero even with an ack present.
    push("reset", mk_in(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 1, 16'h5555), '0);
    push("reset", mk_in(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0), '0);
    // Clean D miss at 0x1236: reads 0x1234..0x1237, done at cycle 5.
    push("cleanD_accept", mk_in(0, 0, 16'h0, 1, 16'h1236, 0, 16'h0, 0, 16'h0), '0);
    for (int k = 0; k < 4; k++)
      push("cleanD_beat", mk_in(0, 0, 16'h0, 1, 16'h1236, 0, 16'h0, 1, 16'hD000 + 16'(k)),
           rd_o(16'h1234 + 16'(k), 1'b1, 2'(k), 1'b1, 16'hD000 + 16'(k)));
    push("cleanD_done", mk_in(0, 0, 16'h0, 1, 16'h1236, 0, 16'h0, 0, 16'h0), done_o(0, 1));
    push("cleanD_idle", mk_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0), '0);
    // Spurious acks in IDLE do nothing.
    push("spurious_ack", mk_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 1, 16'h5555), '0);
    push("spurious_ack", mk_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 1, 16'h6666), '0);
    // Dirty D miss: write back 0x0A18.., then read 0x0040..; address changes ignored.
    push("dirtyD_accept", mk_in(0, 0, 16'h0, 1, 16'h0040, 1, 16'h0A18, 0, 16'h0), '0);
    for (int k = 0; k < 4; k++)
      push("dirtyD_wb", mk_in(0, 0, 16'h0, 1, 16'h7777, 1, 16'h0F0F, 1, 16'h0),
           wr_o(16'h0A18 + 16'(k), 16'hA000 + 16'(k), 2'(k)));
    for (int k = 0; k < 4; k++)
      push("dirtyD_fill", mk_in(0, 0, 16'h0, 1, 16'h7777, 1, 16'h0F0F, 1, 16'hE000 + 16'(k)),
           rd_o(16'h0040 + 16'(k), 1'b1, 2'(k), 1'b1, 16'hE000 + 16'(k)));
    push("dirtyD_done", mk_in(0, 0, 16'h0, 1, 16'h7777, 1, 16'h0F0F, 0, 16'h0), done_o(0, 1));
    push("dirtyD_idle", mk_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0), '0);

    for (int n = 0; n < vecs.size(); n++)
      cyc(labels[n], vecs[n].i, vecs[n].o);

    // I miss at 0x00F1, ack on every third cycle.
    cyc("Iwait_accept", mk_in(0, 1, 16'h00F1, 0, 16'h0, 0, 16'h0, 0, 16'h0), '0);
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 3; w++) begin
        ack = (w == 2);
        rd  = ack ? 16'hC000 + 16'(b) : 16'h0;
        cyc("Iwait_beat", mk_in(0, 1, 16'h00F1, 0, 16'h0, 0, 16'h0, ack, rd),
            rd_o(16'h00F0 + 16'(b), 1'b0, 2'(b), ack, rd));
      end
    cyc("Iwait_done", mk_in(0, 1, 16'h00F1, 0, 16'h0, 0, 16'h0, 0, 16'h0), done_o(1, 0));
    cyc("Iwait_idle", mk_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0), '0);

    // Simultaneous misses: D first, I accepted the cycle after the D miss drops.
    cyc("both_accept", mk_in(0, 1, 16'h3003, 1, 16'h2000, 0, 16'h0, 0, 16'h0), '0);
    for (int k = 0; k < 4; k++)
      cyc("both_D_beat", mk_in(0, 1, 16'h3003, 1, 16'h2000, 0, 16'h0, 1, 16'h1100 + 16'(k)),
          rd_o(16'h2000 + 16'(k), 1'b1, 2'(k), 1'b1, 16'h1100 + 16'(k)));
    cyc("both_D_done", mk_in(0, 1, 16'h3003, 1, 16'h2000, 0, 16'h0, 0, 16'h0), done_o(0, 1));
    cyc("both_I_accept", mk_in(0, 1, 16'h3003, 0, 16'h0, 0, 16'h0, 0, 16'h0), '0);
    for (int k = 0; k < 4; k++)
      cyc("both_I_beat", mk_in(0, 1, 16'h3003, 0, 16'h0, 0, 16'h0, 1, 16'h2200 + 16'(k)),
          rd_o(16'h3000 + 16'(k), 1'b0, 2'(k), 1'b1, 16'h2200 + 16'(k)));
    cyc("both_I_done", mk_in(0, 1, 16'h3003, 0, 16'h0, 0, 16'h0, 0, 16'h0), done_o(1, 0));
    cyc("both_idle", mk_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0), '0);

    // Reset after the second ack of an I refill; refill restarts at beat 0.
    cyc("rstfill_accept", mk_in(0, 1, 16'h0105, 0, 16'h0, 0, 16'h0, 0, 16'h0), '0);
    for (int k = 0; k < 2; k++)
      cyc("rstfill_beat", mk_in(0, 1, 16'h0105, 0, 16'h0, 0, 16'h0, 1, 16'h3300 + 16'(k)),
          rd_o(16'h0104 + 16'(k), 1'b0, 2'(k), 1'b1, 16'h3300 + 16'(k)));
    cyc("rstfill_rst", mk_in(1, 1, 16'h0105, 0, 16'h0, 0, 16'h0, 1, 16'h3302), '0);
    cyc("rstfill_reaccept", mk_in(0, 1, 16'h0105, 0, 16'h0, 0, 16'h0, 0, 16'h0), '0);
    for (int k = 0; k < 4; k++)
      cyc("rstfill_rebeat", mk_in(0, 1, 16'h0105, 0, 16'h0, 0, 16'h0, 1, 16'h4400 + 16'(k)),
          rd_o(16'h0104 + 16'(k), 1'b0, 2'(k), 1'b1, 16'h4400 + 16'(k)));
    cyc("rstfill_done", mk_in(0, 1, 16'h0105, 0, 16'h0, 0, 16'h0, 0, 16'h0), done_o(1, 0));
    cyc("rstfill_idle", mk_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
